// File: rtl/axi4_single_master.sv
// Single-outstanding AXI4 initiator: one valid/ready request becomes one single-beat
// AXI4 read or write, and the outcome comes back as one valid/ready response.
module axi4_single_master #(
    parameter logic [3:0] ID = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RESP} state_t;

    state_t      state;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs;

    assign aw_hs = io_master_awvalid & io_master_awready;
    assign w_hs  = io_master_wvalid & io_master_wready;

    // Fixed fields; burst reads as INCR only while its channel is valid so reset leaves it 0.
    assign io_master_awid    = ID;
    assign io_master_arid    = ID;
    assign io_master_awlen   = 8'd0;
    assign io_master_arlen   = 8'd0;
    assign io_master_awburst = {1'b0, io_master_awvalid};
    assign io_master_arburst = {1'b0, io_master_arvalid};
    assign io_master_awaddr  = addr_q;
    assign io_master_araddr  = addr_q;
    assign io_master_awsize  = size_q;
    assign io_master_arsize  = size_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = io_master_wvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            size_q            <= '0;
            wstrb_q           <= '0;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_err          <= 1'b0;
            io_master_awvalid <= 1'b0;
            io_master_wvalid  <= 1'b0;
            io_master_bready  <= 1'b0;
            io_master_arvalid <= 1'b0;
            io_master_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        size_q    <= (req_size > 3'd2) ? 3'd2 : req_size;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        if (req_wen) begin
                            io_master_awvalid <= 1'b1;
                            io_master_wvalid  <= 1'b1;
                            state             <= WREQ;
                        end else begin
                            io_master_arvalid <= 1'b1;
                            state             <= RADDR;
                        end
                    end
                end
                RADDR: if (io_master_arready) begin
                    io_master_arvalid <= 1'b0;
                    io_master_rready  <= 1'b1;
                    state             <= RDATA;
                end
                RDATA: if (io_master_rvalid) begin
                    io_master_rready <= 1'b0;
                    resp_rdata       <= io_master_rdata;
                    resp_err         <= (io_master_rresp != 2'b00) | !io_master_rlast
                                        | (io_master_rid != ID);
                    resp_valid       <= 1'b1;
                    state            <= RESP;
                end
                WREQ: begin
                    if (aw_hs) begin
                        io_master_awvalid <= 1'b0;
                        aw_done           <= 1'b1;
                    end
                    if (w_hs) begin
                        io_master_wvalid <= 1'b0;
                        w_done           <= 1'b1;
                    end
                    // AW and W may finish in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done          <= 1'b0;
                        w_done           <= 1'b0;
                        io_master_bready <= 1'b1;
                        state            <= WRESP;
                    end
                end
                WRESP: if (io_master_bvalid) begin
                    io_master_bready <= 1'b0;
                    resp_rdata       <= '0;
                    resp_err         <= (io_master_bresp != 2'b00) | (io_master_bid != ID);
                    resp_valid       <= 1'b1;
                    state            <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_single_master.sv
// Bench for axi4_single_master: a randomized AXI slave with fault injection, a word-array
// reference memory, and a response scoreboard drained by an independent monitor.
module tb_axi4_single_master;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_wen = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_size = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err;
    logic        resp_ready = 0;
    logic [31:0] resp_rdata;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [3:0]  bid = 0, rid = 0;
    logic [31:0] rdata = 0;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;

    axi4_single_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst), .io_master_wready(wready), .io_master_wvalid(wvalid),
        .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_bid(bid), .io_master_arready(arready), .io_master_arvalid(arvalid),
        .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
        .io_master_arsize(arsize), .io_master_arburst(arburst), .io_master_rready(rready),
        .io_master_rvalid(rvalid), .io_master_rresp(rresp), .io_master_rdata(rdata),
        .io_master_rlast(rlast), .io_master_rid(rid)
    );

    // fault: 0 none, 1 error resp code, 2 wrong id, 3 rlast low (reads only)
    typedef struct {
        bit          wr;
        int          aw_dly, w_dly, ar_dly, r_dly, b_dly, fault;
        bit          drop;
        logic [31:0] addr, wdata;
        logic [2:0]  rsize, size;
        logic [3:0]  wstrb;
    } plan_t;
    typedef struct { logic [31:0] rdata; bit err; } exp_t;

    plan_t       plan_rq[$], plan_wq[$];
    exp_t        exp_q[$];
    logic [31:0] smem[16];
    logic [31:0] rmem[16];
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic plan_t mk(bit wr, int idx, logic [2:0] sz, logic [31:0] wd,
                                 logic [3:0] ws, int fault);
        plan_t p;
        p.wr = wr; p.fault = fault; p.drop = 0;
        p.aw_dly = 0; p.w_dly = 0; p.ar_dly = 0; p.r_dly = 0; p.b_dly = 0;
        p.addr = 32'h8000_0000 + 32'(idx) * 4;
        p.rsize = sz; p.size = (sz > 3'd2) ? 3'd2 : sz;
        p.wdata = wd; p.wstrb = ws;
        return p;
    endfunction

    // Reference: plain word memory; writes always land, response comes from the fault plan.
    task automatic do_req(input plan_t p);
        exp_t e;
        int   i, n;
        i = int'(p.addr[5:2]);
        if (p.wr) begin
            for (int b = 0; b < 4; b++)
                if (p.wstrb[b]) rmem[i][8*b +: 8] = p.wdata[8*b +: 8];
            e.rdata = 32'h0;
            plan_wq.push_back(p);
        end else begin
            e.rdata = rmem[i];
            plan_rq.push_back(p);
        end
        e.err = (p.fault != 0);
        exp_q.push_back(e);
        n = 0;
        while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin chk("req_ready_timeout", 0, 1); return; end
        req_valid = 1; req_wen = p.wr; req_addr = p.addr; req_size = p.rsize;
        req_wdata = p.wdata; req_wstrb = p.wstrb;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Read slave
    plan_t rp;
    int    rn;
    bit    rhs;
    initial forever begin
        @(posedge clk); #1;
        if (reset && arvalid) begin
            if (plan_rq.size() == 0) begin chk("ar_unplanned", 1, 0); step(1); end
            else begin
                rp = plan_rq.pop_front();
                repeat (rp.ar_dly) begin chk("ar_hold", {arvalid, araddr[30:0]}, {1'b1, rp.addr[30:0]}); step(1); end
                arready = 1;
                chk("araddr", araddr, rp.addr);
                chk("arsize", arsize, rp.size);
                chk("arlen", arlen, 0);
                chk("arburst", arburst, 1);
                chk("arid", arid, 1);
                step(1);
                arready = 0;
                step(rp.r_dly);
                rvalid = 1; rdata = smem[rp.addr[5:2]];
                rresp = (rp.fault == 1) ? 2'b10 : 2'b00;
                rlast = (rp.fault != 3);
                rid   = (rp.fault == 2) ? 4'h3 : 4'h1;
                rn = 0; rhs = 0;
                while (!rhs && rn < (rp.drop ? 3 : 200)) begin rhs = rready; step(1); rn++; end
                if (rp.drop) chk("late_rvalid_ignored", rhs, 0);
                else if (!rhs) chk("r_timeout", 0, 1);
                rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 0;
            end
        end
    end

    // Write slave
    plan_t       wp;
    logic [31:0] wd_c;
    logic [3:0]  ws_c;
    int          bn;
    bit          bhs;
    initial forever begin
        @(posedge clk); #1;
        if (reset && (awvalid || wvalid)) begin
            if (plan_wq.size() == 0) begin chk("aw_unplanned", 1, 0); step(1); end
            else begin
                wp = plan_wq.pop_front();
                fork
                    begin
                        repeat (wp.aw_dly) begin chk("aw_hold", {awvalid, awaddr[30:0]}, {1'b1, wp.addr[30:0]}); step(1); end
                        awready = 1;
                        chk("awaddr", awaddr, wp.addr);
                        chk("awsize", awsize, wp.size);
                        chk("awlen", awlen, 0);
                        chk("awburst", awburst, 1);
                        chk("awid", awid, 1);
                        step(1);
                        awready = 0;
                    end
                    begin
                        repeat (wp.w_dly) begin chk("w_hold", {wvalid, wdata[30:0]}, {1'b1, wp.wdata[30:0]}); step(1); end
                        wready = 1;
                        wd_c = wdata; ws_c = wstrb;
                        chk("wdata", wdata, wp.wdata);
                        chk("wstrb", wstrb, wp.wstrb);
                        chk("wlast", wlast, 1);
                        step(1);
                        wready = 0;
                    end
                join
                for (int b = 0; b < 4; b++)
                    if (ws_c[b]) smem[wp.addr[5:2]][8*b +: 8] = wd_c[8*b +: 8];
                step(wp.b_dly);
                bvalid = 1;
                bresp = (wp.fault == 1) ? 2'b10 : 2'b00;
                bid   = (wp.fault == 2) ? 4'h5 : 4'h1;
                bn = 0; bhs = 0;
                while (!bhs && bn < 200) begin bhs = bready; step(1); bn++; end
                if (!bhs) chk("b_timeout", 0, 1);
                bvalid = 0; bresp = 0; bid = 0;
            end
        end
    end

    bit rr_force = 1, rr_val = 1;
    always @(posedge clk) begin
        #1;
        resp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard pop on each response handshake, plus hold-stability check.
    exp_t        me;
    int          resp_cnt = 0;
    bit          held = 0;
    logic [31:0] held_data = 0;
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (held) chk("resp_stable", resp_rdata, held_data);
            if (resp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    me = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, me.rdata);
                    chk("resp_err", resp_err, me.err);
                end
            end
        end
        held = resp_valid && !resp_ready;
        held_data = resp_rdata;
    end

    plan_t p;
    int    cnt0, n, idx;
    logic [31:0] d;
    initial begin
        for (int i = 0; i < 16; i++) begin smem[i] = $urandom; rmem[i] = smem[i]; end
        smem[1] = 32'hDEADBEEF; rmem[1] = 32'hDEADBEEF;

        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid, wlast}, 0);
        chk("rst_addr", awaddr | araddr | resp_rdata, 0);
        chk("rst_ids", {awid, arid}, 8'h11);
        @(posedge clk); #1; reset = 1;
        step(1);
        chk("req_ready_after_reset", req_ready, 1);

        // Zero-wait read latency
        p = mk(0, 1, 2, 0, 0, 0);
        do_req(p);
        chk("rd_c1_arvalid", arvalid, 1);
        step(1);
        chk("rd_c2_rready", rready, 1);
        chk("rd_c2_no_resp", resp_valid, 0);
        step(1);
        chk("rd_c3_resp_valid", resp_valid, 1);
        chk("rd_c3_rdata", resp_rdata, 32'hDEADBEEF);
        drain();

        // Write with AW delayed 3 cycles
        p = mk(1, 4, 1, 32'h12345678, 4'b0011, 0);
        p.aw_dly = 3;
        do_req(p);
        chk("wr_c1_valids", {awvalid, wvalid}, 2'b11);
        step(1);
        chk("wr_c2_valids", {awvalid, wvalid}, 2'b10);
        step(2);
        chk("wr_c4_valids", {awvalid, bready}, 2'b10);
        step(1);
        chk("wr_c5_valids", {awvalid, bready}, 2'b01);
        drain();

        // Each read fault, then a good read
        for (int f = 1; f <= 3; f++) do_req(mk(0, $urandom_range(0, 15), 2, 0, 0, f));
        do_req(mk(0, $urandom_range(0, 15), 2, 0, 0, 0));
        drain();

        // Response backpressure for 10 cycles
        rr_val = 0; step(2);
        do_req(mk(0, 7, 2, 0, 0, 0));
        n = 0;
        while (!resp_valid && n < 50) begin step(1); n++; end
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_rdata, rmem[7]);
            chk("bp_req_ready", req_ready, 0);
            step(1);
        end
        rr_val = 1;
        n = 0;
        while (resp_valid && n < 10) begin step(1); n++; end
        chk("bp_done_req_ready", {resp_valid, req_ready}, 2'b01);

        // Reset while in RDATA; the late rvalid must not produce a response
        p = mk(0, 2, 2, 0, 0, 0);
        p.r_dly = 6; p.drop = 1;
        do_req(p);
        step(1);
        chk("rdata_state_rready", rready, 1);
        #2 reset = 0;
        #1;
        chk("midrst_outputs", {arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready}, 0);
        chk("midrst_addr", araddr | resp_rdata, 0);
        void'(exp_q.pop_back());
        step(2);
        reset = 1;
        cnt0 = resp_cnt;
        step(14);
        chk("no_resp_after_reset", resp_cnt - cnt0, 0);
        do_req(mk(0, 3, 2, 0, 0, 0));
        drain();

        // Back-to-back write/read pairs
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 15); d = $urandom;
            p = mk(1, idx, 2, d, 4'hF, 0);
            p.aw_dly = $urandom_range(0, 2); p.w_dly = $urandom_range(0, 2);
            do_req(p);
            p = mk(0, idx, 2, 0, 0, 0);
            p.ar_dly = $urandom_range(0, 2); p.r_dly = $urandom_range(0, 2);
            do_req(p);
        end
        drain();

        // Random mix with faults, clamped sizes and random backpressure
        rr_force = 0;
        for (int k = 0; k < 40; k++) begin
            p = mk($urandom_range(0, 1), $urandom_range(0, 15), 3'($urandom_range(0, 3)),
                   $urandom, 4'($urandom), 0);
            p.fault = p.wr ? $urandom_range(0, 5) : $urandom_range(0, 6);
            if (p.fault > (p.wr ? 2 : 3)) p.fault = 0;
            p.aw_dly = $urandom_range(0, 3); p.w_dly = $urandom_range(0, 3);
            p.ar_dly = $urandom_range(0, 3); p.r_dly = $urandom_range(0, 3);
            p.b_dly  = $urandom_range(0, 3);
            do_req(p);
        end
        drain();
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
